// File: rtl/i3c_pkg.sv
// Shared CCC codes, FSM states and helpers for the target CCC address handler.
package i3c_pkg;

   localparam logic [7:0] CCC_RSTDAA   = 8'h06;
   localparam logic [7:0] CCC_SETAASA  = 8'h29;
   localparam logic [7:0] CCC_RSTACT_B = 8'h2A;
   localparam logic [7:0] CCC_SETDASA  = 8'h87;
   localparam logic [7:0] CCC_SETNEWDA = 8'h88;
   localparam logic [7:0] CCC_RSTACT_D = 8'h9A;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_BCAST,
      ST_DIR_DEF,
      ST_DIR_ADDR,
      ST_DIR_DATA,
      ST_COMMIT_M,
      ST_COMMIT_V
   } state_e;

   // Which address update is waiting for the end of the frame.
   typedef enum logic [1:0] {
      KIND_NONE,
      KIND_DASA,
      KIND_RSTDAA,
      KIND_NEWDA
   } kind_e;

   // A proposed address byte is unusable when it is 0x00, the broadcast
   // address 0x7E, or carries a set LSB.
   function automatic logic addr_byte_rejected(input logic [7:0] b);
      return (b[7:1] == 7'h00) || (b[7:1] == 7'h7E) || b[0];
   endfunction

endpackage

// File: rtl/ccc_addr_cfg.sv
// Target-side CCC handler: decodes address-assignment and reset-action CCCs,
// pends the result for the main and virtual device, and commits on STOP.
module ccc_addr_cfg
   import i3c_pkg::*;
#(
   parameter bit VirtEn = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       ccc_valid_i,
   input  logic [7:0] ccc_i,
   input  logic       addr_valid_i,
   input  logic [6:0] addr_i,
   input  logic       addr_rnw_i,
   input  logic       data_valid_i,
   input  logic [7:0] data_i,
   input  logic       stop_i,
   input  logic [6:0] static_addr_i,
   input  logic       static_addr_valid_i,
   input  logic [6:0] virt_static_addr_i,
   input  logic       virt_static_addr_valid_i,
   input  logic [6:0] dyn_addr_i,
   input  logic       dyn_addr_valid_i,
   input  logic [6:0] virt_dyn_addr_i,
   input  logic       virt_dyn_addr_valid_i,
   input  logic       rstact_clr_i,
   output logic       addr_ack_o,
   output logic [6:0] set_dasa_o,
   output logic       set_dasa_valid_o,
   output logic       set_dasa_virtual_device_o,
   output logic       rstdaa_o,
   output logic [6:0] newda_o,
   output logic       set_newda_o,
   output logic       set_newda_virtual_device_o,
   output logic [7:0] rst_action_o,
   output logic       rst_action_valid_o,
   output logic       err_o
);

   state_e     r_state, w_state_d;
   kind_e      r_kind, w_kind_d;
   logic [7:0] r_ccc, w_ccc_d;
   logic [7:0] r_def, w_def_d;
   logic       r_def_done, w_def_done_d;
   logic       r_tgt_v, w_tgt_v_d;
   logic       r_pend_m, w_pend_m_d;
   logic       r_pend_v, w_pend_v_d;
   logic [6:0] r_addr_m, w_addr_m_d;
   logic [6:0] r_addr_v, w_addr_v_d;
   logic       r_addr_ack, w_addr_ack_d;
   logic       r_err, w_err_d;
   logic [7:0] r_rst_action;
   logic       r_rst_action_valid;
   logic       w_ract_latch;
   logic [7:0] w_ract_val;
   logic       w_match_m, w_match_v;
   logic       w_pulse, w_pulse_virt;
   logic [6:0] w_pulse_addr;

   // Header direction plays no part in address matching.
   logic w_unused;
   assign w_unused = addr_rnw_i;

   // Address-header match for the CCC currently being decoded; main has priority.
   always_comb begin
      w_match_m = 1'b0;
      w_match_v = 1'b0;
      if (r_ccc == CCC_SETDASA) begin
         w_match_m = static_addr_valid_i && !dyn_addr_valid_i && (addr_i == static_addr_i);
         w_match_v = VirtEn && virt_static_addr_valid_i && !virt_dyn_addr_valid_i &&
                     (addr_i == virt_static_addr_i);
      end else begin
         w_match_m = dyn_addr_valid_i && (addr_i == dyn_addr_i);
         w_match_v = VirtEn && virt_dyn_addr_valid_i && (addr_i == virt_dyn_addr_i);
      end
      w_match_v = w_match_v && !w_match_m;
   end

   // Next-state decode, pending bookkeeping and commit pulse generation.
   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      w_state_d    = r_state;
      w_kind_d     = r_kind;
      w_ccc_d      = r_ccc;
      w_def_d      = r_def;
      w_def_done_d = r_def_done;
      w_tgt_v_d    = r_tgt_v;
      w_pend_m_d   = r_pend_m;
      w_pend_v_d   = r_pend_v;
      w_addr_m_d   = r_addr_m;
      w_addr_v_d   = r_addr_v;
      w_addr_ack_d = 1'b0;
      w_err_d      = 1'b0;
      w_ract_latch = 1'b0;
      w_ract_val   = 8'h00;
      w_pulse      = 1'b0;
      w_pulse_virt = 1'b0;
      w_pulse_addr = 7'h00;
      set_dasa_o                 = 7'h00;
      set_dasa_valid_o           = 1'b0;
      set_dasa_virtual_device_o  = 1'b0;
      rstdaa_o                   = 1'b0;
      newda_o                    = 7'h00;
      set_newda_o                = 1'b0;
      set_newda_virtual_device_o = 1'b0;

      if (ccc_valid_i && (r_state != ST_COMMIT_M) && (r_state != ST_COMMIT_V)) begin
         // A new CCC restarts decode and drops anything an unfinished frame pended.
         w_ccc_d      = ccc_i;
         w_def_done_d = 1'b0;
         w_pend_m_d   = 1'b0;
         w_pend_v_d   = 1'b0;
         w_kind_d     = KIND_NONE;
         case (ccc_i)
            CCC_RSTDAA: begin
               w_state_d  = ST_BCAST;
               w_kind_d   = KIND_RSTDAA;
               w_pend_m_d = 1'b1;
               w_pend_v_d = VirtEn;
            end
            CCC_SETAASA: begin
               w_state_d  = ST_BCAST;
               w_kind_d   = KIND_DASA;
               w_pend_m_d = static_addr_valid_i && !dyn_addr_valid_i;
               w_addr_m_d = static_addr_i;
               w_pend_v_d = VirtEn && virt_static_addr_valid_i && !virt_dyn_addr_valid_i;
               w_addr_v_d = virt_static_addr_i;
            end
            CCC_RSTACT_D:              w_state_d = ST_DIR_DEF;
            CCC_SETDASA, CCC_SETNEWDA: w_state_d = ST_DIR_ADDR;
            default:                   w_state_d = ST_BCAST;
         endcase
      end else begin
         case (r_state)
            ST_BCAST: begin
               if (data_valid_i && (r_ccc == CCC_RSTACT_B) && !r_def_done) begin
                  w_def_done_d = 1'b1;
                  w_ract_latch = 1'b1;
                  w_ract_val   = data_i;
               end
            end
            ST_DIR_DEF: begin
               if (data_valid_i) begin
                  w_def_d   = data_i;
                  w_state_d = ST_DIR_ADDR;
               end
            end
            ST_DIR_ADDR: begin
               if (addr_valid_i && (w_match_m || w_match_v)) begin
                  w_addr_ack_d = 1'b1;
                  w_tgt_v_d    = w_match_v;
                  w_state_d    = ST_DIR_DATA;
                  if (r_ccc == CCC_RSTACT_D) begin
                     w_ract_latch = 1'b1;
                     w_ract_val   = r_def;
                  end
               end
            end
            ST_DIR_DATA: begin
               if (data_valid_i) begin
                  w_state_d = ST_DIR_ADDR;
                  if (r_ccc != CCC_RSTACT_D) begin
                     if (addr_byte_rejected(data_i)) begin
                        w_err_d = 1'b1;
                     end else begin
                        w_kind_d = (r_ccc == CCC_SETDASA) ? KIND_DASA : KIND_NEWDA;
                        if (r_tgt_v) begin
                           w_pend_v_d = 1'b1;
                           w_addr_v_d = data_i[7:1];
                        end else begin
                           w_pend_m_d = 1'b1;
                           w_addr_m_d = data_i[7:1];
                        end
                     end
                  end
               end
            end
            ST_COMMIT_M: begin
               w_state_d    = ST_COMMIT_V;
               w_pulse      = r_pend_m;
               w_pulse_addr = r_addr_m;
            end
            ST_COMMIT_V: begin
               w_state_d    = ST_IDLE;
               w_pend_m_d   = 1'b0;
               w_pend_v_d   = 1'b0;
               w_kind_d     = KIND_NONE;
               w_pulse      = r_pend_v && VirtEn;
               w_pulse_virt = 1'b1;
               w_pulse_addr = r_addr_v;
            end
            default: ;
         endcase

         // STOP closes the frame; a write pended in this same cycle still commits.
         if (stop_i && (r_state inside {ST_BCAST, ST_DIR_DEF, ST_DIR_ADDR, ST_DIR_DATA})) begin
            w_state_d = (w_pend_m_d || w_pend_v_d) ? ST_COMMIT_M : ST_IDLE;
         end
      end

      if (w_pulse) begin
         case (r_kind)
            KIND_DASA: begin
               set_dasa_valid_o          = 1'b1;
               set_dasa_o                = w_pulse_addr;
               set_dasa_virtual_device_o = w_pulse_virt;
            end
            KIND_RSTDAA: begin
               rstdaa_o                  = 1'b1;
               set_dasa_virtual_device_o = w_pulse_virt;
            end
            KIND_NEWDA: begin
               set_newda_o                = 1'b1;
               newda_o                    = w_pulse_addr;
               set_newda_virtual_device_o = w_pulse_virt;
            end
            default: ;
         endcase
      end
   end

   // State, pending and strobe registers; the clear input beats a same-cycle latch.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state            <= ST_IDLE;
         r_kind             <= KIND_NONE;
         r_ccc              <= 8'h00;
         r_def              <= 8'h00;
         r_def_done         <= 1'b0;
         r_tgt_v            <= 1'b0;
         r_pend_m           <= 1'b0;
         r_pend_v           <= 1'b0;
         r_addr_m           <= 7'h00;
         r_addr_v           <= 7'h00;
         r_addr_ack         <= 1'b0;
         r_err              <= 1'b0;
         r_rst_action       <= 8'h00;
         r_rst_action_valid <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_kind     <= w_kind_d;
         r_ccc      <= w_ccc_d;
         r_def      <= w_def_d;
         r_def_done <= w_def_done_d;
         r_tgt_v    <= w_tgt_v_d;
         r_pend_m   <= w_pend_m_d;
         r_pend_v   <= w_pend_v_d;
         r_addr_m   <= w_addr_m_d;
         r_addr_v   <= w_addr_v_d;
         r_addr_ack <= w_addr_ack_d;
         r_err      <= w_err_d;
         if (rstact_clr_i) begin
            r_rst_action       <= 8'h00;
            r_rst_action_valid <= 1'b0;
         end else if (w_ract_latch) begin
            r_rst_action       <= w_ract_val;
            r_rst_action_valid <= 1'b1;
         end
      end
   end

   assign addr_ack_o         = r_addr_ack;
   assign err_o              = r_err;
   assign rst_action_o       = r_rst_action;
   assign rst_action_valid_o = r_rst_action_valid;

endmodule

// File: tb/tb_ccc_addr_cfg.sv
// Directed-random bench for ccc_addr_cfg: one instance with the virtual device
// enabled, one with it tied off, both fed the same frames.
module tb_ccc_addr_cfg;
   import i3c_pkg::*;

   localparam int K_NONE = 0, K_DASA = 1, K_RSTDAA = 2, K_NEWDA = 3;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       ccc_valid_i, addr_valid_i, addr_rnw_i, data_valid_i, stop_i, rstact_clr_i;
   logic [7:0] ccc_i, data_i;
   logic [6:0] addr_i, static_addr_i, virt_static_addr_i, dyn_addr_i, virt_dyn_addr_i;
   logic       static_addr_valid_i, virt_static_addr_valid_i, dyn_addr_valid_i, virt_dyn_addr_valid_i;

   logic       ack_a, dasa_v_a, dasa_virt_a, rstdaa_a, newda_s_a, newda_virt_a, ract_v_a, err_a;
   logic [6:0] dasa_a, newda_a;
   logic [7:0] ract_a;
   logic       ack_b, dasa_v_b, dasa_virt_b, rstdaa_b, newda_s_b, newda_virt_b, ract_v_b, err_b;
   logic [6:0] dasa_b, newda_b;
   logic [7:0] ract_b;
   logic [18:0] obs_a, obs_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   ccc_addr_cfg #(.VirtEn(1'b1)) u_dut_a (
      .clk_i(clk_i), .rst_ni(rst_ni), .ccc_valid_i(ccc_valid_i), .ccc_i(ccc_i),
      .addr_valid_i(addr_valid_i), .addr_i(addr_i), .addr_rnw_i(addr_rnw_i),
      .data_valid_i(data_valid_i), .data_i(data_i), .stop_i(stop_i),
      .static_addr_i(static_addr_i), .static_addr_valid_i(static_addr_valid_i),
      .virt_static_addr_i(virt_static_addr_i), .virt_static_addr_valid_i(virt_static_addr_valid_i),
      .dyn_addr_i(dyn_addr_i), .dyn_addr_valid_i(dyn_addr_valid_i),
      .virt_dyn_addr_i(virt_dyn_addr_i), .virt_dyn_addr_valid_i(virt_dyn_addr_valid_i),
      .rstact_clr_i(rstact_clr_i), .addr_ack_o(ack_a),
      .set_dasa_o(dasa_a), .set_dasa_valid_o(dasa_v_a), .set_dasa_virtual_device_o(dasa_virt_a),
      .rstdaa_o(rstdaa_a), .newda_o(newda_a), .set_newda_o(newda_s_a),
      .set_newda_virtual_device_o(newda_virt_a), .rst_action_o(ract_a),
      .rst_action_valid_o(ract_v_a), .err_o(err_a)
   );

   ccc_addr_cfg #(.VirtEn(1'b0)) u_dut_b (
      .clk_i(clk_i), .rst_ni(rst_ni), .ccc_valid_i(ccc_valid_i), .ccc_i(ccc_i),
      .addr_valid_i(addr_valid_i), .addr_i(addr_i), .addr_rnw_i(addr_rnw_i),
      .data_valid_i(data_valid_i), .data_i(data_i), .stop_i(stop_i),
      .static_addr_i(static_addr_i), .static_addr_valid_i(static_addr_valid_i),
      .virt_static_addr_i(virt_static_addr_i), .virt_static_addr_valid_i(virt_static_addr_valid_i),
      .dyn_addr_i(dyn_addr_i), .dyn_addr_valid_i(dyn_addr_valid_i),
      .virt_dyn_addr_i(virt_dyn_addr_i), .virt_dyn_addr_valid_i(virt_dyn_addr_valid_i),
      .rstact_clr_i(rstact_clr_i), .addr_ack_o(ack_b),
      .set_dasa_o(dasa_b), .set_dasa_valid_o(dasa_v_b), .set_dasa_virtual_device_o(dasa_virt_b),
      .rstdaa_o(rstdaa_b), .newda_o(newda_b), .set_newda_o(newda_s_b),
      .set_newda_virtual_device_o(newda_virt_b), .rst_action_o(ract_b),
      .rst_action_valid_o(ract_v_b), .err_o(err_b)
   );

   // All commit-side outputs packed together so one compare covers exclusivity too.
   assign obs_a = {dasa_v_a, dasa_a, dasa_virt_a, rstdaa_a, newda_s_a, newda_a, newda_virt_a};
   assign obs_b = {dasa_v_b, dasa_b, dasa_virt_b, rstdaa_b, newda_s_b, newda_b, newda_virt_b};

   // Expected packed commit outputs for one pulse of the given kind.
   function automatic logic [18:0] ev(input int kind, input int addr, input bit virt);
      logic [6:0] a;
      a = 7'(addr);
      case (kind)
         K_DASA:   return {1'b1, a, virt, 1'b0, 1'b0, 7'h00, 1'b0};
         K_RSTDAA: return {1'b0, 7'h00, virt, 1'b1, 1'b0, 7'h00, 1'b0};
         K_NEWDA:  return {1'b0, 7'h00, 1'b0, 1'b0, 1'b1, a, virt};
         default:  return 19'h0;
      endcase
   endfunction

   // A data byte is a usable new address when even and its upper seven bits are neither 0 nor 0x7E.
   function automatic bit accepts(input int d);
      return (d % 2 == 0) && (d / 2 != 0) && (d / 2 != 126);
   endfunction

   function automatic int rand_addr();
      return int'($urandom_range(8, 119));
   endfunction

   function automatic int rand_data();
      if ($urandom_range(0, 1) == 1) return rand_addr() * 2;
      return int'($urandom_range(0, 255));
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_ccc(input int c);
      ccc_i = 8'(c); ccc_valid_i = 1'b1;
      @(negedge clk_i);
      ccc_valid_i = 1'b0;
   endtask

   task automatic send_addr(input int a);
      addr_i = 7'(a); addr_rnw_i = 1'b0; addr_valid_i = 1'b1;
      @(negedge clk_i);
      addr_valid_i = 1'b0;
   endtask

   task automatic send_data(input int d);
      data_i = 8'(d); data_valid_i = 1'b1;
      @(negedge clk_i);
      data_valid_i = 1'b0;
   endtask

   // STOP, then the main-slot cycle, the virtual-slot cycle and a quiet cycle.
   task automatic do_stop(input string tag, input logic [18:0] m_a, input logic [18:0] v_a,
                          input logic [18:0] m_b, input logic [18:0] v_b);
      stop_i = 1'b1;
      @(negedge clk_i);
      stop_i = 1'b0;
      check({tag, "_main_a"}, 32'(obs_a), 32'(m_a));
      check({tag, "_main_b"}, 32'(obs_b), 32'(m_b));
      @(negedge clk_i);
      check({tag, "_virt_a"}, 32'(obs_a), 32'(v_a));
      check({tag, "_virt_b"}, 32'(obs_b), 32'(v_b));
      @(negedge clk_i);
      check({tag, "_quiet_a"}, 32'(obs_a), 32'h0);
      check({tag, "_quiet_b"}, 32'(obs_b), 32'h0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_obs_a"}, 32'(obs_a), 32'h0);
      check({tag, "_obs_b"}, 32'(obs_b), 32'h0);
      check({tag, "_misc_a"}, {21'h0, ack_a, err_a, ract_v_a, ract_a}, 32'h0);
      check({tag, "_misc_b"}, {21'h0, ack_b, err_b, ract_v_b, ract_b}, 32'h0);
   endtask

   initial begin
      int s, s2, a, d, r1, r2, exp_addr;
      bit hit, tgt_v, have;

      rst_ni = 1'b0;
      ccc_valid_i = 0; ccc_i = 0; addr_valid_i = 0; addr_i = 0; addr_rnw_i = 0;
      data_valid_i = 0; data_i = 0; stop_i = 0; rstact_clr_i = 0;
      static_addr_i = 0; static_addr_valid_i = 0; virt_static_addr_i = 0; virt_static_addr_valid_i = 0;
      dyn_addr_i = 0; dyn_addr_valid_i = 0; virt_dyn_addr_i = 0; virt_dyn_addr_valid_i = 0;
      repeat (2) @(negedge clk_i);
      check_all_zero("reset");
      rst_ni = 1'b1;
      @(negedge clk_i);

      // SETDASA to static 0x30 with new address 0x29.
      static_addr_i = 7'h30; static_addr_valid_i = 1'b1;
      send_ccc(CCC_SETDASA);
      send_addr(32'h30);
      check("setdasa_ack_a", 32'(ack_a), 32'h1);
      check("setdasa_ack_b", 32'(ack_b), 32'h1);
      send_data(32'h52);
      check("setdasa_err", 32'(err_a), 32'h0);
      do_stop("setdasa", ev(K_DASA, 32'h29, 1'b0), 19'h0, ev(K_DASA, 32'h29, 1'b0), 19'h0);

      // Randomised SETDASA: header hit or miss, data byte accepted or rejected.
      for (int i = 0; i < 4; i++) begin
         s = rand_addr();
         static_addr_i = 7'(s);
         hit = ($urandom_range(0, 1) == 1);
         a = hit ? s : (s ^ 1);
         d = rand_data();
         send_ccc(CCC_SETDASA);
         send_addr(a);
         check("rdasa_ack", 32'(ack_a), 32'(hit));
         send_data(d);
         check("rdasa_err", 32'(err_a), 32'(hit && !accepts(d)));
         if (hit && accepts(d))
            do_stop("rdasa", ev(K_DASA, d / 2, 1'b0), 19'h0, ev(K_DASA, d / 2, 1'b0), 19'h0);
         else
            do_stop("rdasa", 19'h0, 19'h0, 19'h0, 19'h0);
      end

      // Broadcast RSTDAA with both devices holding dynamic addresses.
      static_addr_valid_i = 1'b0;
      dyn_addr_i = 7'h20; dyn_addr_valid_i = 1'b1;
      virt_dyn_addr_i = 7'h11; virt_dyn_addr_valid_i = 1'b1;
      send_ccc(CCC_RSTDAA);
      send_data(rand_data());
      do_stop("rstdaa", ev(K_RSTDAA, 0, 1'b0), ev(K_RSTDAA, 0, 1'b1), ev(K_RSTDAA, 0, 1'b0), 19'h0);

      // SETNEWDA to the virtual device with the broadcast address as payload.
      send_ccc(CCC_SETNEWDA);
      send_addr(32'h11);
      check("newda7e_ack_a", 32'(ack_a), 32'h1);
      check("newda7e_ack_b", 32'(ack_b), 32'h0);
      send_data(32'hFC);
      check("newda7e_err_a", 32'(err_a), 32'h1);
      check("newda7e_err_b", 32'(err_b), 32'h0);
      do_stop("newda7e", 19'h0, 19'h0, 19'h0, 19'h0);

      // Randomised SETNEWDA with two writes per frame: the last accepted one wins.
      for (int i = 0; i < 3; i++) begin
         tgt_v = ($urandom_range(0, 1) == 1);
         a = tgt_v ? 32'h11 : 32'h20;
         have = 1'b0;
         exp_addr = 0;
         send_ccc(CCC_SETNEWDA);
         for (int k = 0; k < 2; k++) begin
            send_addr(a);
            check("rnewda_ack_a", 32'(ack_a), 32'h1);
            check("rnewda_ack_b", 32'(ack_b), 32'(!tgt_v));
            d = rand_data();
            send_data(d);
            check("rnewda_err_a", 32'(err_a), 32'(!accepts(d)));
            if (accepts(d)) begin
               have = 1'b1;
               exp_addr = d / 2;
            end
         end
         if (!have)
            do_stop("rnewda", 19'h0, 19'h0, 19'h0, 19'h0);
         else if (tgt_v)
            do_stop("rnewda", 19'h0, ev(K_NEWDA, exp_addr, 1'b1), 19'h0, 19'h0);
         else
            do_stop("rnewda", ev(K_NEWDA, exp_addr, 1'b0), 19'h0, ev(K_NEWDA, exp_addr, 1'b0), 19'h0);
      end

      // Direct RSTACT: defining byte 0x01 latched when dynamic 0x20 matches.
      send_ccc(CCC_RSTACT_D);
      send_data(32'h01);
      check("drstact_pre", 32'(ract_v_a), 32'h0);
      send_addr(32'h20);
      check("drstact_ack", 32'(ack_a), 32'h1);
      check("drstact_val", {23'h0, ract_v_a, ract_a}, 32'h101);
      do_stop("drstact", 19'h0, 19'h0, 19'h0, 19'h0);
      check("drstact_held", {23'h0, ract_v_a, ract_a}, 32'h101);
      rstact_clr_i = 1'b1;
      @(negedge clk_i);
      rstact_clr_i = 1'b0;
      check("drstact_clr", {23'h0, ract_v_a, ract_a}, 32'h0);

      // Broadcast RSTACT: only the first data byte counts.
      r1 = int'($urandom_range(0, 255));
      r2 = int'($urandom_range(0, 255));
      send_ccc(CCC_RSTACT_B);
      send_data(r1);
      check("brstact_first", {23'h0, ract_v_b, ract_b}, 32'h100 | 32'(r1));
      send_data(r2);
      check("brstact_second", {23'h0, ract_v_a, ract_a}, 32'h100 | 32'(r1));
      do_stop("brstact", 19'h0, 19'h0, 19'h0, 19'h0);
      rstact_clr_i = 1'b1;
      @(negedge clk_i);
      check("brstact_clr", {23'h0, ract_v_a, ract_a}, 32'h0);
      rstact_clr_i = 1'b0;

      // Clear arriving together with the latching byte wins.
      send_ccc(CCC_RSTACT_B);
      rstact_clr_i = 1'b1;
      send_data(rand_data());
      rstact_clr_i = 1'b0;
      check("brstact_clr_wins", {23'h0, ract_v_a, ract_a}, 32'h0);
      do_stop("brstact2", 19'h0, 19'h0, 19'h0, 19'h0);

      // SETAASA with both static addresses valid and no dynamic addresses.
      s = rand_addr();
      s2 = rand_addr();
      static_addr_i = 7'(s); static_addr_valid_i = 1'b1;
      virt_static_addr_i = 7'(s2); virt_static_addr_valid_i = 1'b1;
      dyn_addr_valid_i = 1'b0; virt_dyn_addr_valid_i = 1'b0;
      send_ccc(CCC_SETAASA);
      do_stop("setaasa", ev(K_DASA, s, 1'b0), ev(K_DASA, s2, 1'b1), ev(K_DASA, s, 1'b0), 19'h0);

      // SETAASA when only the main device already has a dynamic address.
      dyn_addr_valid_i = 1'b1;
      send_ccc(CCC_SETAASA);
      do_stop("setaasa_vonly", 19'h0, ev(K_DASA, s2, 1'b1), 19'h0, 19'h0);

      // A new CCC mid-frame discards the pended SETDASA write.
      dyn_addr_valid_i = 1'b0; virt_static_addr_valid_i = 1'b0;
      send_ccc(CCC_SETDASA);
      send_addr(s);
      check("abort_ack", 32'(ack_a), 32'h1);
      send_data(rand_addr() * 2);
      send_ccc(32'h7F);
      do_stop("abort", 19'h0, 19'h0, 19'h0, 19'h0);

      // STOP while idle is a no-op.
      do_stop("idle_stop", 19'h0, 19'h0, 19'h0, 19'h0);

      // Reset after SETNEWDA data, before STOP, with a reset action latched.
      send_ccc(CCC_RSTACT_B);
      send_data(32'h55);
      do_stop("pre_rst", 19'h0, 19'h0, 19'h0, 19'h0);
      dyn_addr_i = 7'h20; dyn_addr_valid_i = 1'b1;
      send_ccc(CCC_SETNEWDA);
      send_addr(32'h20);
      send_data(32'h44);
      rst_ni = 1'b0;
      @(negedge clk_i);
      check_all_zero("midrst");
      rst_ni = 1'b1;
      @(negedge clk_i);
      do_stop("post_rst", 19'h0, 19'h0, 19'h0, 19'h0);
      check_all_zero("post_rst_all");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ccc_addr_cfg.md
# ccc_addr_cfg

Target-side CCC address/reset-action handler. Consumes the decoded CCC frame stream from the target bus FSM and handles SETDASA, SETAASA, SETNEWDA, RSTDAA and RSTACT (broadcast and direct). Produces the address-update and reset-action strobes consumed directly by the CSR interface, for both the main and the virtual target device.

## Interface
Parameters:
- VirtEn, 1, enables virtual-device matching and virtual commit pulses; 0 ties all virtual paths off.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- ccc_valid_i / ccc_i  in  1/8  CCC code captured after a 7E/W header
- addr_valid_i / addr_i / addr_rnw_i  in  1/7/1  direct-CCC address header after Sr
- data_valid_i / data_i  in  1/8  data or defining byte
- stop_i  in  1  end of CCC frame (STOP)
- static_addr_i / static_addr_valid_i  in  7/1  main static address
- virt_static_addr_i / virt_static_addr_valid_i  in  7/1
- dyn_addr_i / dyn_addr_valid_i  in  7/1  current main dynamic address
- virt_dyn_addr_i / virt_dyn_addr_valid_i  in  7/1
- rstact_clr_i  in  1  clears the latched reset action
- addr_ack_o  out  1  registered; address header matched
- set_dasa_o / set_dasa_valid_o / set_dasa_virtual_device_o  out  7/1/1
- rstdaa_o  out  1
- newda_o / set_newda_o / set_newda_virtual_device_o  out  7/1/1
- rst_action_o / rst_action_valid_o  out  8/1  level
- err_o  out  1  pulse; rejected address byte

## Operation
- States: IDLE, BCAST, DIR_DEF, DIR_ADDR, DIR_DATA, COMMIT_M, COMMIT_V.
- IDLE + ccc_valid_i:
  - 0x06 RSTDAA: go to BCAST, pend reset on both devices.
  - 0x29 SETAASA: go to BCAST, pend main if static_addr_valid_i && !dyn_addr_valid_i; same rule for virtual.
  - 0x2A RSTACT: go to BCAST, expect defining byte.
  - 0x9A: go to DIR_DEF.
  - 0x87, 0x88: go to DIR_ADDR.
  - Other codes: go to BCAST, no action.
- BCAST: the first data byte under RSTACT latches rst_action_o and sets rst_action_valid_o. Other bytes are ignored.
- DIR_DEF: the data byte is stored as the defining byte, then go to DIR_ADDR.
- DIR_ADDR + addr_valid_i, match rules:
  - SETDASA matches static (valid) with dynamic not valid.
  - SETNEWDA matches a valid dynamic address.
  - RSTACT matches a valid dynamic address.
  - Virtual is checked only when the main device does not match.
- DIR_ADDR, on match: addr_ack_o pulses, record the target (main/virtual), go to DIR_DATA. On miss: stay in DIR_ADDR (next Sr header).
- DIR_ADDR, RSTACT on match: the defining byte is latched as the reset action immediately.
- DIR_DATA + data_valid_i: new address = data_i[7:1].
  - Reject if 0x00, 0x7E, or data_i[0]=1: err_o pulses and nothing is pended.
  - Otherwise pend the address for the recorded target. The last valid write wins.
  - Then go to DIR_ADDR.
- Any state except COMMIT + stop_i: go to COMMIT_M if anything is pended, else IDLE.
- COMMIT_M: one-cycle main pulse if pended: set_dasa_valid_o (SETDASA/SETAASA), rstdaa_o, or set_newda_o; virtual flag = 0. Next state COMMIT_V.
- COMMIT_V: same pulses with the virtual flag = 1, if the virtual device is pended and VirtEn. Next state IDLE.
- Output exclusivity: a set_dasa/rstdaa pulse is never asserted in the same cycle as set_newda_o.
- rst_action_valid_o stays high until rstact_clr_i; rstact_clr_i wins over a same-cycle latch.

## Timing
- Reset values: all outputs 0; state IDLE; pending cleared.
- addr_ack_o: 1 cycle after addr_valid_i.
- Commit pulses: main pulse 1 cycle after stop_i, virtual pulse 2 cycles after stop_i.
- Inputs received during COMMIT_* are ignored. stop_i in IDLE is a no-op.
- ccc_valid_i outside IDLE aborts the current frame, discards pending, and restarts decode.
- Reset mid-frame discards all pending state; a latched rst_action is also cleared.
- Addresses appear on the data outputs only during their pulse cycle; otherwise the outputs are 0.

## Structure
- i3c_pkg holds:
  - CCC code constants: RSTDAA 0x06, SETAASA 0x29, RSTACT_B 0x2A, SETDASA 0x87, SETNEWDA 0x88, RSTACT_D 0x9A.
  - The state enum.
- Single module, no sub-module. One FSM plus pending registers: pend_m, pend_v, kind, addr_m, addr_v.

## Test plan
- SETDASA, static 0x30, no dynamic address; addr 0x30/W, data 0x52, stop → addr_ack_o, then set_dasa_o=0x29 with set_dasa_valid_o (virtual flag 0) 1 cycle after stop.
- Broadcast RSTDAA with both devices holding a dynamic address, stop → rstdaa_o pulse with virtual flag 0, then a pulse with virtual flag 1 on the next cycle.
- SETNEWDA to virtual dynamic 0x11, data 0xFC (→0x7E), stop → err_o pulse, no set_newda_o.
- Direct RSTACT, defining byte 0x01, dynamic address 0x20 matched → rst_action_o=0x01, rst_action_valid_o held; rstact_clr_i → cleared.
- SETAASA, static valid, VirtEn=0 → single set_dasa pulse with static address, no virtual pulse.
- rst_ni asserted after SETNEWDA data, before stop → no pulses after reset release; all outputs 0.
